// File: rtl/gate_array_pkg.sv
// Shared types and helpers for the gate_array bitwise logic unit.
// gate_fn is the single definition of the eight selectable bitwise functions.
package gate_array_pkg;

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_XOR    = 3'd2,
        OP_NAND   = 3'd3,
        OP_NOR    = 3'd4,
        OP_XNOR   = 3'd5,
        OP_ANDN   = 3'd6,
        OP_PASS_A = 3'd7
    } op_e;

    localparam int SKID_DEPTH = 2;

    // Evaluated at the widest supported width; callers truncate to their WIDTH.
    function automatic logic [63:0] gate_fn(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input op_e         op);
        logic [63:0] r;
        r = a;
        case (op)
            OP_AND:    r = a & b;
            OP_OR:     r = a | b;
            OP_XOR:    r = a ^ b;
            OP_NAND:   r = ~(a & b);
            OP_NOR:    r = ~(a | b);
            OP_XNOR:   r = ~(a ^ b);
            OP_ANDN:   r = a & ~b;
            OP_PASS_A: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_array_skid.sv
// Two-entry FIFO-ordered output skid buffer, generic payload width W.
// Latency: a push is visible at the head in the cycle after the accepting edge.
// Backpressure: push_rdy is a flop equal to (occupancy < 2); never combinational on pop_rdy.
module gate_array_skid
    import gate_array_pkg::*;
#(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);

    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic [1:0]   occ_q;
    logic [1:0]   occ_nxt;
    logic         full_q;
    logic         push;
    logic         pop;

    assign push_rdy = ~full_q;
    assign pop_vld  = (occ_q != 2'd0);
    assign pop_dat  = pop_vld ? head_q : '0;
    assign push     = push_vld & push_rdy;
    assign pop      = pop_vld & pop_rdy;

    always_comb begin
        occ_nxt = occ_q;
        if (push && !pop)
            occ_nxt = occ_q + 2'd1;
        else if (!push && pop)
            occ_nxt = occ_q - 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
            full_q <= 1'b0;
        end else begin
            occ_q  <= occ_nxt;
            full_q <= (occ_nxt == 2'(SKID_DEPTH));
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0)
                        head_q <= push_dat;
                    else
                        tail_q <= push_dat;
                end
                2'b01:   head_q <= tail_q;
                // Push+pop only happens at occupancy 1: new data goes straight to head.
                2'b11:   head_q <= push_dat;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/gate_array.sv
// Registered WIDTH-bit bitwise logic unit (8 ops) with 2-entry output skid; GATE_ARRAY_STATS_EN adds a pop counter.
// Latency: 1 cycle from accept to out_valid; 1 transaction/cycle with out_ready held high.
// Backpressure: in_ready is registered (occupancy < 2) and independent of out_ready in the same cycle.
module gate_array
    import gate_array_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_all,
    output logic             y_any,
    output logic [CNT_W-1:0] txn_count
);

    logic [WIDTH-1:0] y_calc;
    logic [WIDTH+1:0] push_dat;
    logic [WIDTH+1:0] pop_dat;

    assign y_calc   = WIDTH'(gate_fn(64'(a), 64'(b), op_e'(op)));
    assign push_dat = {y_calc, &y_calc, |y_calc};

    gate_array_skid #(
        .W (WIDTH + 2)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (in_valid),
        .push_rdy (in_ready),
        .push_dat (push_dat),
        .pop_vld  (out_valid),
        .pop_rdy  (out_ready),
        .pop_dat  (pop_dat)
    );

    assign y     = pop_dat[WIDTH+1:2];
    assign y_all = pop_dat[1];
    assign y_any = pop_dat[0];

`ifdef GATE_ARRAY_STATS_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating: holds at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (out_valid && out_ready && (cnt_q != '1))
            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign txn_count = cnt_q;
`else
    assign txn_count = '0;
`endif

endmodule
